// File: rtl/rv32_pkg.sv
// Shared RV32 widths and the writeback request record used by the load path.
package rv32_pkg;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  live;
        logic [XLEN-1:0]       data;
    } wb_req_t;
endpackage

// File: rtl/wb_load_fifo.sv
// Small load-return FIFO with per-entry live bits that can be squashed by destination register.
module wb_load_fifo
    import rv32_pkg::*;
#(
    parameter int unsigned LOAD_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  wb_req_t                        push_req,
    input  logic                           pop,
    input  logic [NUM_REGS-1:0]            squash_mask,
    output logic                           full,
    output logic                           empty,
    output wb_req_t                        head,
    output wb_req_t [LOAD_DEPTH-1:0]       entries
);
    localparam int unsigned PTR_W = $clog2(LOAD_DEPTH) + 1;
    localparam int unsigned IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);

    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    wb_req_t [LOAD_DEPTH-1:0] mem_q, mem_d;
    logic [IDX_W-1:0]         wr_idx, rd_idx;

    assign wr_idx  = wr_ptr_q[IDX_W-1:0];
    assign rd_idx  = rd_ptr_q[IDX_W-1:0];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);
    assign head    = mem_q[rd_idx];
    assign entries = mem_q;

    // Slots outside the occupied window always hold live=0, so entries can be ORed blindly.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < int'(LOAD_DEPTH); i++) begin
            if (squash_mask[mem_q[i].rd]) begin
                mem_d[i].live = 1'b0;
            end
        end
        if (pop) begin
            mem_d[rd_idx].live = 1'b0;
        end
        if (push) begin
            mem_d[wr_idx] = push_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            mem_q <= mem_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end
endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write port owner: merges ALU writebacks with buffered load returns,
// squashes stale loads, forwards the same-cycle write and exports pending destinations.
module reg_writeback_unit
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN       = rv32_pkg::XLEN,
    parameter int unsigned LOAD_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4:0]            load_rd,
    input  logic [XLEN-1:0]       load_data,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [NUM_REGS-1:0]   rd_pending,
    output logic                  write_enable,
    output logic [4:0]            addr_3,
    output logic [XLEN-1:0]       write_data,
    output logic [4:0]            addr_1,
    output logic [4:0]            addr_2,
    input  logic [XLEN-1:0]       read_data_1,
    input  logic [XLEN-1:0]       read_data_2
);
    logic                     alu_wr, load_push, head_pop, fifo_full, fifo_empty;
    logic [NUM_REGS-1:0]      squash_mask;
    wb_req_t                  push_req, head;
    wb_req_t [LOAD_DEPTH-1:0] entries;

    assign load_ready = !fifo_full;
    assign alu_wr     = alu_valid && (alu_rd != 5'd0);
    // A same-rd ALU write in the handshake cycle is younger, so the load is dropped.
    assign load_push  = load_valid && load_ready && (load_rd != 5'd0)
                        && !(alu_wr && (alu_rd == load_rd));
    assign head_pop   = !alu_wr && !fifo_empty;

    assign push_req.rd   = load_rd;
    assign push_req.live = 1'b1;
    assign push_req.data = load_data;

    always_comb begin
        squash_mask = '0;
        if (alu_wr) begin
            squash_mask[alu_rd] = 1'b1;
        end
        if (load_push) begin
            squash_mask[load_rd] = 1'b1;
        end
        squash_mask[0] = 1'b0;
    end

    wb_load_fifo #(
        .LOAD_DEPTH (LOAD_DEPTH)
    ) u_load_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (load_push),
        .push_req    (push_req),
        .pop         (head_pop),
        .squash_mask (squash_mask),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head        (head),
        .entries     (entries)
    );

    always_comb begin
        write_enable = !reset && (alu_wr || (head_pop && head.live));
        addr_3       = alu_wr ? alu_rd : head.rd;
        write_data   = alu_wr ? alu_data : head.data;
    end

    always_comb begin
        rd_pending = '0;
        for (int i = 0; i < int'(LOAD_DEPTH); i++) begin
            if (entries[i].live) begin
                rd_pending[entries[i].rd] = 1'b1;
            end
        end
        rd_pending[0] = 1'b0;
    end

    assign addr_1 = rs1_addr;
    assign addr_2 = rs2_addr;

    always_comb begin
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (write_enable && (addr_3 == rs1_addr)) begin
            rs1_data = write_data;
        end else begin
            rs1_data = read_data_1;
        end
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (write_enable && (addr_3 == rs2_addr)) begin
            rs2_data = write_data;
        end else begin
            rs2_data = read_data_2;
        end
    end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit with a behavioural reg_file and write scoreboard.
module tb_reg_writeback_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, load_valid, load_ready, write_enable;
    logic [4:0]  alu_rd, load_rd, rs1_addr, rs2_addr, addr_3, addr_1, addr_2;
    logic [31:0] alu_data, load_data, rs1_data, rs2_data, rd_pending, write_data;
    logic [31:0] read_data_1, read_data_2;

    logic [31:0] rf [32];
    logic        rf_clear;
    logic        use_tbl;
    logic [31:0] tbl_rd1, tbl_rd2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t load_q[$];

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic [4:0]  r1, r2;
        logic [31:0] d1, d2;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd, e1, e2;
    } vec_t;
    vec_t vecs[5];

    int applied    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_writeback_unit dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_rd      (load_rd),
        .load_data    (load_data),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rd_pending   (rd_pending),
        .write_enable (write_enable),
        .addr_3       (addr_3),
        .write_data   (write_data),
        .addr_1       (addr_1),
        .addr_2       (addr_2),
        .read_data_1  (read_data_1),
        .read_data_2  (read_data_2)
    );

    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (write_enable) begin
            rf[addr_3] <= write_data;
        end
    end

    always_comb begin
        read_data_1 = use_tbl ? tbl_rd1 : rf[addr_1];
        read_data_2 = use_tbl ? tbl_rd2 : rf[addr_2];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Checks the write port at the falling edge, then advances to just after the next rising edge.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (!reset && alu_valid && alu_rd != 5'd0) begin
            chk("alu_we", {31'd0, write_enable}, 32'd1);
            chk("alu_addr", {27'd0, addr_3}, {27'd0, alu_rd});
            chk("alu_data", write_data, alu_data);
        end else if (write_enable) begin
            if (load_q.size() == 0) begin
                chk("spurious_we", {31'd0, write_enable}, 32'd0);
            end else begin
                e = load_q.pop_front();
                chk("load_addr", {27'd0, addr_3}, {27'd0, e.rd});
                chk("load_data", write_data, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid  = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [31:0] d);
        load_valid = 1'b1;
        load_rd    = rd;
        load_data  = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd6, 32'h1111, 32'h2222,
                    1'b1, 5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h2222};
        vecs[1] = '{1'b1, 5'd0,  32'h1234,      5'd0,  5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    1'b0, 5'd0,  32'h0,         32'h0, 32'h0};
        vecs[2] = '{1'b0, 5'd5,  32'hAAAA,      5'd5,  5'd5, 32'h1, 32'h2,
                    1'b0, 5'd0,  32'h0,         32'h1, 32'h2};
        vecs[3] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd30, 32'h5, 32'h6,
                    1'b1, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h6};
        vecs[4] = '{1'b1, 5'd1,  32'h77,        5'd2,  5'd1, 32'h8, 32'h9,
                    1'b1, 5'd1,  32'h77,        32'h8, 32'h77};

        reset = 1'b1; rf_clear = 1'b1; use_tbl = 1'b0; tbl_rd1 = '0; tbl_rd2 = '0;
        drive_alu(1'b0, 5'd0, 32'h0);
        load_valid = 1'b0; load_rd = '0; load_data = '0; rs1_addr = '0; rs2_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {31'd0, write_enable}, 32'd0);
        chk("rst_pending", rd_pending, 32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd1);
        reset = 1'b0; rf_clear = 1'b0;
        @(posedge clk);
        #1;

        // Combinational write port and forwarding with an empty FIFO.
        use_tbl = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_alu(vecs[i].av, vecs[i].ard, vecs[i].adata);
            rs1_addr = vecs[i].r1; rs2_addr = vecs[i].r2;
            tbl_rd1 = vecs[i].d1;  tbl_rd2 = vecs[i].d2;
            #2;
            chk("vec_we", {31'd0, write_enable}, {31'd0, vecs[i].we});
            if (vecs[i].we) begin
                chk("vec_addr3", {27'd0, addr_3}, {27'd0, vecs[i].a3});
                chk("vec_wdata", write_data, vecs[i].wd);
            end
            chk("vec_rs1", rs1_data, vecs[i].e1);
            chk("vec_rs2", rs2_data, vecs[i].e2);
            tick();
        end
        use_tbl = 1'b0; idle(); rs1_addr = '0; rs2_addr = '0;

        // Load buffering behind a busy ALU, then drain in order.
        drive_alu(1'b1, 5'd7, 32'h70); drive_load(5'd3, 32'hA0A0_A0A0);
        #2 chk("buf_ready0", {31'd0, load_ready}, 32'd1);
        load_q.push_back('{5'd3, 32'hA0A0_A0A0});
        tick();
        drive_alu(1'b1, 5'd7, 32'h71); drive_load(5'd4, 32'hB0B0_B0B0);
        #2 chk("buf_ready1", {31'd0, load_ready}, 32'd1);
        load_q.push_back('{5'd4, 32'hB0B0_B0B0});
        tick();
        idle();
        #2 chk("buf_full", {31'd0, load_ready}, 32'd0);
        chk("buf_pending34", rd_pending, 32'h0000_0018);
        tick();
        #2 chk("buf_ready_back", {31'd0, load_ready}, 32'd1);
        chk("buf_pending4", rd_pending, 32'h0000_0010);
        tick();
        chk("buf_pending0", rd_pending, 32'd0);
        chk("buf_x3", rf[3], 32'hA0A0_A0A0);
        chk("buf_x4", rf[4], 32'hB0B0_B0B0);

        // WAW squash by a younger ALU write.
        drive_load(5'd9, 32'h0000_0999);
        tick();
        idle(); drive_alu(1'b1, 5'd9, 32'h9999_0000);
        #2 chk("waw_pending", rd_pending, 32'h0000_0200);
        tick();
        idle();
        #2 chk("waw_squashed", rd_pending, 32'd0);
        chk("waw_dead_pop_we", {31'd0, write_enable}, 32'd0);
        tick();
        chk("waw_x9", rf[9], 32'h9999_0000);

        // x0 handling: neither source writes x0, x0 reads as zero.
        use_tbl = 1'b1; tbl_rd1 = 32'hFFFF_FFFF; rs1_addr = 5'd0;
        drive_alu(1'b1, 5'd0, 32'h5555); drive_load(5'd0, 32'h6666);
        #2 chk("x0_we", {31'd0, write_enable}, 32'd0);
        chk("x0_ready", {31'd0, load_ready}, 32'd1);
        chk("x0_rs1", rs1_data, 32'd0);
        tick();
        idle();
        #2 chk("x0_not_queued", rd_pending, 32'd0);
        chk("x0_we_after", {31'd0, write_enable}, 32'd0);
        tick();
        use_tbl = 1'b0;

        // alu_rd==0 leaves the port to the load head.
        drive_alu(1'b1, 5'd0, 32'h1); drive_load(5'd13, 32'h0C0C_0C0C);
        load_q.push_back('{5'd13, 32'h0C0C_0C0C});
        tick();
        load_valid = 1'b0;
        #2 chk("rd0_head_we", {31'd0, write_enable}, 32'd1);
        tick();
        idle();

        // Same-cycle ALU and load to one rd: only the ALU value lands.
        drive_alu(1'b1, 5'd12, 32'h1212_0000); drive_load(5'd12, 32'h0000_1212);
        #2 chk("conf_ready", {31'd0, load_ready}, 32'd1);
        tick();
        idle();
        #2 chk("conf_pending", rd_pending, 32'd0);
        chk("conf_we", {31'd0, write_enable}, 32'd0);
        tick();
        chk("conf_x12", rf[12], 32'h1212_0000);

        // Two queued loads to the same rd: the older one dies.
        drive_alu(1'b1, 5'd7, 32'h72); drive_load(5'd10, 32'h0000_00AA);
        tick();
        drive_load(5'd10, 32'h0000_00BB);
        load_q.push_back('{5'd10, 32'h0000_00BB});
        tick();
        idle();
        #2 chk("dup_pending", rd_pending, 32'h0000_0400);
        chk("dup_old_dead", {31'd0, write_enable}, 32'd0);
        tick();
        #2 chk("dup_new_we", {31'd0, write_enable}, 32'd1);
        tick();
        chk("dup_x10", rf[10], 32'h0000_00BB);

        // Asynchronous reset with two live loads queued.
        drive_alu(1'b1, 5'd7, 32'h73); drive_load(5'd20, 32'h2020_2020);
        tick();
        drive_load(5'd21, 32'h2121_2121);
        tick();
        idle();
        #1 chk("rst_mid_we_before", {31'd0, write_enable}, 32'd1);
        chk("rst_mid_pending_before", rd_pending, 32'h0030_0000);
        #1 reset = 1'b1;
        #1 chk("rst_mid_we", {31'd0, write_enable}, 32'd0);
        chk("rst_mid_pending", rd_pending, 32'd0);
        chk("rst_mid_ready", {31'd0, load_ready}, 32'd1);
        tick();
        reset = 1'b0;
        #2 chk("rst_mid_we_after", {31'd0, write_enable}, 32'd0);
        tick();
        chk("rst_mid_x20", rf[20], 32'd0);
        chk("rst_mid_x21", rf[21], 32'd0);
        chk("rst_mid_x3", rf[3], 32'hA0A0_A0A0);

        chk("scoreboard_drained", load_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
